// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
// Optional build macro: MULTDIV_EARLY_EXIT_EN (zero operand / zero divisor finishes immediately).
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // rstatus codes selected by writeback when the unit flags an exception
  localparam logic [2:0] RSTATUS_MUL_OVF = 3'd4;
  localparam logic [2:0] RSTATUS_DIV_EXC = 3'd5;

  // Absolute value kept one bit wider so 0x80000000 maps to +2^31 without wrapping
  function automatic logic [MD_WIDTH:0] magnitude(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? ({1'b0, ~v} + 1'b1) : {1'b0, v};
  endfunction

endpackage

// File: rtl/md_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module md_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             in_bit,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Remainder stays below the divisor, so the difference always fits WIDTH bits
  always_comb begin
    shifted = {rem_in, in_bit};
    q_bit   = (shifted >= divisor);
    rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor[WIDTH-1:0]) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_multdiv.sv
// Iterative signed 32-bit multiply/divide beside the single-cycle ALU.
// Radix-2 shift-add multiply and restoring divide on magnitudes, WIDTH
// iterations each, one DONE cycle carrying the RDY pulse.
// Optional build macro: MULTDIV_EARLY_EXIT_EN.
module iter_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             is_div,
  output logic [4:0]       rd_out
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // shifted multiplicand
  logic [WIDTH:0]     opb_q, opb_d;       // multiplier (shifts right) or divisor
  logic [2*WIDTH-1:0] work_q, work_d;     // mul: accumulator; div: {remainder, dividend/quotient}
  logic               neg_q, neg_d;
  logic               special_q, special_d; // div by zero or MIN / -1
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               is_div_q, is_div_d;
  logic [4:0]         rd_q, rd_d;

  logic [WIDTH:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0] sum, prod;
  logic [WIDTH-1:0]   rem_nxt, quo;
  logic               q_bit, last, start, start_mul, start_div;

  md_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (work_q[2*WIDTH-1:WIDTH]),
    .in_bit  (work_q[WIDTH-1]),
    .divisor (opb_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Next-state, iteration datapath and operand capture on accepted starts
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    work_d    = work_q;
    neg_d     = neg_q;
    special_d = special_q;
    res_d     = res_q;
    exc_d     = exc_q;
    is_div_d  = is_div_q;
    rd_d      = rd_q;

    a_mag     = magnitude(operandA);
    b_mag     = magnitude(operandB);
    start_mul = ctrl_MULT;
    start_div = ctrl_DIV & ~ctrl_MULT;
    start     = ((state_q == IDLE) || (state_q == DONE)) && (ctrl_MULT || ctrl_DIV);
    last      = (cnt_q == CNT_W'(WIDTH-1));
    sum       = work_q + (opb_q[0] ? mcand_q : '0);
    prod      = neg_q ? -sum : sum;
    quo       = {work_q[WIDTH-2:0], q_bit};

    case (state_q)
      MUL: begin
        work_d  = sum;
        mcand_d = mcand_q << 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          res_d   = prod[WIDTH-1:0];
          exc_d   = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end
      end
      DIV: begin
        work_d = {rem_nxt, quo};
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          res_d   = special_q ? '0 : (neg_q ? -quo : quo);
          exc_d   = special_q;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (start) begin
      state_d   = start_mul ? MUL : DIV;
      cnt_d     = '0;
      is_div_d  = start_div;
      rd_d      = rd_in;
      neg_d     = operandA[WIDTH-1] ^ operandB[WIDTH-1];
      mcand_d   = {{(WIDTH-1){1'b0}}, a_mag};
      opb_d     = b_mag;
      work_d    = start_mul ? '0 : {{(WIDTH-1){1'b0}}, a_mag};
      special_d = start_div && ((operandB == '0) ||
                  ((operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (operandB == '1)));
`ifdef MULTDIV_EARLY_EXIT_EN
      if (start_mul && ((operandA == '0) || (operandB == '0))) begin
        state_d = DONE;
        res_d   = '0;
        exc_d   = 1'b0;
      end else if (start_div && (operandB == '0)) begin
        state_d = DONE;
        res_d   = '0;
        exc_d   = 1'b1;
      end
`endif
    end
  end

  // State and datapath registers; reset abandons any op in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      work_q    <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      is_div_q  <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      work_q    <= work_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      is_div_q  <= is_div_d;
      rd_q      <= rd_d;
    end
  end

  assign busy           = (state_q == MUL) || (state_q == DIV);
  assign data_resultRDY = (state_q == DONE);
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign is_div         = is_div_q;
  assign rd_out         = rd_q;

endmodule

// File: tb/tb_iter_multdiv.sv
// Self-checking bench for iter_multdiv: an arithmetic reference model plus a
// per-cycle compare process, with directed vectors and literal expectations.
module tb_iter_multdiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] operandA = '0, operandB = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, data_resultRDY, data_exception, is_div;
  logic [31:0] data_result;
  logic [4:0]  rd_out;

  iter_multdiv dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .operandA(operandA), .operandB(operandB), .rd_in(rd_in),
    .busy(busy), .data_resultRDY(data_resultRDY), .data_result(data_result),
    .data_exception(data_exception), .is_div(is_div), .rd_out(rd_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Model state: op in flight, cycle its result appears, expected outputs
  bit          chk_en    = 0;
  bit          active    = 0;
  bit          zero_outs = 1;
  int          rdy_cyc   = 0;
  logic [31:0] e_res;
  logic        e_exc, e_isdiv;
  logic [4:0]  e_rd;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {exception, result} from plain signed arithmetic
  function automatic logic [32:0] ref_op(input bit d, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    if (!d) begin
      p = longint'(signed'(a)) * longint'(signed'(b));
      return {(p != longint'(signed'(p[31:0]))), p[31:0]};
    end
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return {1'b1, 32'd0};
    q = signed'(a) / signed'(b);
    return {1'b0, q};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", busy, active && cyc < rdy_cyc);
      chk("rdy", data_resultRDY, active && cyc == rdy_cyc);
      if (active && cyc >= rdy_cyc) begin
        chk("result", data_result, e_res);
        chk("exc", data_exception, e_exc);
        chk("is_div", is_div, e_isdiv);
        chk("rd_out", rd_out, e_rd);
      end else if (zero_outs) begin
        chk("rst_result", data_result, 0);
        chk("rst_exc", data_exception, 0);
        chk("rst_is_div", is_div, 0);
        chk("rst_rd_out", rd_out, 0);
      end
    end
  end

  // Drive one start pulse from the low phase; model decides acceptance
  task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bit early, dv;
    logic [32:0] r;
    ctrl_MULT = m; ctrl_DIV = d; operandA = a; operandB = b; rd_in = rd;
    @(posedge clock); #1;
    if (!active || (cyc - 1) >= rdy_cyc) begin
      dv    = !m && d;
      early = 0;
`ifdef MULTDIV_EARLY_EXIT_EN
      early = dv ? (b == 0) : (a == 0 || b == 0);
`endif
      r       = ref_op(dv, a, b);
      e_res   = r[31:0];
      e_exc   = r[32];
      e_isdiv = dv;
      e_rd    = rd;
      rdy_cyc = cyc + (early ? 0 : 32);
      active  = 1;
      zero_outs = 0;
    end
    ctrl_MULT = 0; ctrl_DIV = 0;
  endtask

  // Bounded wait until the model's DONE cycle; leaves us at its negedge
  task automatic wait_done(input string name);
    bit hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cyc >= rdy_cyc) begin hit = 1; break; end
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string name, input logic [32:0] lit);
    @(negedge clock);
    pulse(m, d, a, b, rd);
    wait_done(name);
    chk(name, {data_exception, data_result}, lit);
  endtask

  initial begin
    // Pin the reference model itself with hand-computed values
    chk("pin_mul_7x-6", ref_op(0, 32'd7, -32'sd6), {1'b0, 32'hFFFF_FFD6});
    chk("pin_mul_ovf", ref_op(0, 32'h0001_0000, 32'h0001_0000), {1'b1, 32'h0});
    chk("pin_div_-100/7", ref_op(1, -32'sd100, 32'd7), {1'b0, 32'hFFFF_FFF2});
    chk("pin_div_by0", ref_op(1, 32'd5, 32'd0), {1'b1, 32'h0});
    chk("pin_div_min", ref_op(1, 32'h8000_0000, 32'hFFFF_FFFF), {1'b1, 32'h0});
    chk("pin_mul_min", ref_op(0, 32'h8000_0000, 32'd1), {1'b0, 32'h8000_0000});

    repeat (3) @(posedge clock);
    #1 chk_en = 1;
    @(negedge clock) reset = 0;

    run_op(1, 0, 32'd7, -32'sd6, 5'd3, "t_mul_7x-6", {1'b0, 32'hFFFF_FFD6});
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd4, "t_mul_ovf", {1'b1, 32'h0});
    run_op(0, 1, -32'sd100, 32'd7, 5'd12, "t_div_-100/7", {1'b0, 32'hFFFF_FFF2});
    chk("t_div_rd", rd_out, 5'd12);
    chk("t_div_isdiv", is_div, 1);
    repeat (4) @(negedge clock);   // hold interval checked by the compare process
    run_op(0, 1, 32'd5, 32'd0, 5'd1, "t_div_by0", {1'b1, 32'h0});
    run_op(1, 0, 32'd0, 32'd99, 5'd2, "t_mul_zero", {1'b0, 32'h0});
    run_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd6, "t_mul_ovf2", {1'b1, 32'hFFFF_FFFE});
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, "t_div_min", {1'b1, 32'h0});
    // back-to-back start issued in the DONE cycle
    pulse(1, 0, 32'h8000_0000, 32'd1, 5'd8);
    wait_done("t_mul_min");
    chk("t_mul_min", {data_exception, data_result}, {1'b0, 32'h8000_0000});
    // both strobes high: multiply wins
    run_op(1, 1, 32'd6, 32'd3, 5'd9, "t_both", {1'b0, 32'd18});
    chk("t_both_isdiv", is_div, 0);

    // ignored start mid-op, then reset abandons the op
    @(negedge clock);
    pulse(1, 0, 32'd123, -32'sd45, 5'd10);
    repeat (4) @(negedge clock);
    pulse(0, 1, 32'd50, 32'd5, 5'd11);
    repeat (4) @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    active = 0; zero_outs = 1;
    @(negedge clock) reset = 0;
    repeat (40) @(negedge clock);  // no RDY may appear

    run_op(1, 0, -32'sd3, -32'sd5, 5'd13, "t_mul_neg", {1'b0, 32'd15});
    pulse(0, 1, 32'd100, -32'sd9, 5'd14);
    wait_done("t_div_b2b");
    chk("t_div_b2b", {data_exception, data_result}, {1'b0, 32'hFFFF_FFF5});
    chk("t_div_b2b_rd", rd_out, 5'd14);
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
